// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the radix-4 Booth sequencer
package booth_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      EVAL  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } booth_state_t;

   localparam logic [1:0] OP_ZERO = 2'b00;
   localparam logic [1:0] OP_M    = 2'b01;
   localparam logic [1:0] OP_2M   = 2'b10;

   localparam booth_state_t RST_STATE  = IDLE;
   localparam logic [1:0]   RST_OP_SEL = OP_ZERO;
   localparam logic         RST_OP_NEG = 1'b0;

endpackage

// File: rtl/booth_recode.sv
// rtl/booth_recode.sv - radix-4 Booth triplet {Q1,Q0,q-1} to {op_sel, op_neg}
module booth_recode
   import booth_pkg::*;
(
   input  logic [2:0] i_bits,
   output logic [1:0] o_op_sel,
   output logic       o_op_neg
);

   always_comb begin
      o_op_sel = RST_OP_SEL;
      o_op_neg = RST_OP_NEG;
      case (i_bits)
         3'b001, 3'b010: o_op_sel = OP_M;
         3'b011:         o_op_sel = OP_2M;
         3'b100: begin
            o_op_sel = OP_2M;
            o_op_neg = 1'b1;
         end
         3'b101, 3'b110: begin
            o_op_sel = OP_M;
            o_op_neg = 1'b1;
         end
         default: begin
            o_op_sel = OP_ZERO;
            o_op_neg = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - sequencing FSM for the radix-4 Booth multiplier datapath
// Optional BOOTH_SKIP_ZERO_EN: zero-multiple iterations shift in EVAL and skip SHIFT.
module booth_seq_ctrl
   import booth_pkg::*;
#(
   parameter int N     = 8,
   parameter int CNT_W = $clog2(N/2) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_booth_bits,
   output logic             o_load,
   output logic             o_shift,
   output logic             o_add_en,
   output logic [1:0]       o_op_sel,
   output logic             o_op_neg,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_iter
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N/2 - 1);

   booth_state_t     r_state;
   booth_state_t     w_next;
   logic [CNT_W-1:0] r_iter;
   logic             w_iter_clr;
   logic             w_iter_inc;
   logic             w_last;
   logic [1:0]       w_rc_sel;
   logic             w_rc_neg;

   booth_recode u_recode (
      .i_bits   (i_booth_bits),
      .o_op_sel (w_rc_sel),
      .o_op_neg (w_rc_neg)
   );

   assign w_last = (r_iter == LAST_ITER);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= RST_STATE;
         r_iter  <= '0;
      end else begin
         r_state <= w_next;
         if (w_iter_clr)
            r_iter <= '0;
         else if (w_iter_inc)
            r_iter <= r_iter + CNT_W'(1);
      end
   end

   always_comb begin
      w_next     = r_state;
      w_iter_clr = 1'b0;
      w_iter_inc = 1'b0;
      o_load     = 1'b0;
      o_shift    = 1'b0;
      o_add_en   = 1'b0;
      o_done     = 1'b0;
      o_op_sel   = RST_OP_SEL;
      o_op_neg   = RST_OP_NEG;
      case (r_state)
         IDLE: begin
            if (i_start)
               w_next = LOAD;
         end
         LOAD: begin
            o_load     = 1'b1;
            w_iter_clr = 1'b1;
            w_next     = EVAL;
         end
         EVAL: begin
            o_op_sel = w_rc_sel;
            o_op_neg = w_rc_neg;
            o_add_en = (w_rc_sel != OP_ZERO);
            w_next   = SHIFT;
`ifdef BOOTH_SKIP_ZERO_EN
            // Nothing to accumulate: fold the shift into this cycle.
            if (w_rc_sel == OP_ZERO) begin
               o_shift    = 1'b1;
               w_iter_inc = 1'b1;
               w_next     = w_last ? DONE : EVAL;
            end
`endif
         end
         SHIFT: begin
            o_shift    = 1'b1;
            w_iter_inc = 1'b1;
            w_next     = w_last ? DONE : EVAL;
         end
         DONE: begin
            o_done = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign o_busy = (r_state != IDLE);
   assign o_iter = r_iter;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - directed self-checking bench for booth_seq_ctrl
module tb_booth_seq_ctrl;

    localparam int N     = 8;
    localparam int CNT_W = 3;
`ifdef BOOTH_SKIP_ZERO_EN
    localparam int DC0 = 6;
`else
    localparam int DC0 = 10;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       bb;
    logic             load, shift, add_en, op_neg, busy, done;
    logic [1:0]       op_sel;
    logic [CNT_W-1:0] iter;

    int total = 0;
    int bad   = 0;

    logic [2:0] rc_bits [4];
    logic [1:0] rc_sel  [4];
    logic       rc_neg  [4];

    booth_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_booth_bits (bb),
        .o_load       (load),
        .o_shift      (shift),
        .o_add_en     (add_en),
        .o_op_sel     (op_sel),
        .o_op_neg     (op_neg),
        .o_busy       (busy),
        .o_done       (done),
        .o_iter       (iter)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk(tag, {load, shift, add_en, op_sel, op_neg, busy, done}, 8'h00);
        chk(tag, iter, 3'd0);
    endtask

    initial begin
        rc_bits = '{3'b011, 3'b100, 3'b110, 3'b001};
        rc_sel  = '{2'b10, 2'b10, 2'b01, 2'b01};
        rc_neg  = '{1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; bb = 3'b000;
        tick(); tick();
        chk_idle_zero("reset_state");
        rst = 1'b0;
        tick(); tick();
        chk("idle_busy", busy, 1'b0);

`ifndef BOOTH_SKIP_ZERO_EN
        bb = 3'b000; start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk("a_load", load, (c == 1));
            chk("a_shift", shift, (c == 3 || c == 5 || c == 7 || c == 9));
            chk("a_done", done, (c == 10));
            chk("a_busy", busy, (c >= 1 && c <= 10));
            chk("a_add_en", add_en, 1'b0);
            if (c >= 10) chk("a_iter_hold", iter, 3'd4);
            start = (c == 4);
            tick();
        end
`else
        bb = 3'b111; start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk("s1_load", load, (c == 1));
            chk("s1_shift", shift, (c >= 2 && c <= 5));
            chk("s1_done", done, (c == 6));
            chk("s1_add_en", add_en, 1'b0);
            if (c == 6) chk("s1_iter", iter, 3'd4);
            tick();
        end
        bb = 3'b011; start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk("s2_shift", shift, (c == 3 || c == 4 || c == 6 || c == 7));
            chk("s2_add_en", add_en, (c == 2 || c == 5));
            chk("s2_done", done, (c == 8));
            bb = (c + 1 == 2 || c + 1 == 5) ? 3'b011 : 3'b000;
            tick();
        end
`endif

        bb = rc_bits[0]; start = 1'b1;
        tick(); start = 1'b0;
        chk("r_load", load, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r_eval_sel", op_sel, rc_sel[i]);
            chk("r_eval_neg", op_neg, rc_neg[i]);
            chk("r_eval_add", add_en, 1'b1);
            chk("r_eval_shift", shift, 1'b0);
            if (i < 3) bb = rc_bits[i + 1];
            tick();
            chk("r_shift", shift, 1'b1);
            chk("r_shift_sel", {op_sel, op_neg, add_en}, 4'h0);
        end
        tick();
        chk("r_done", done, 1'b1);
        chk("r_iter", iter, 3'd4);
        tick();

        bb = 3'b000; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("m_busy_pre", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk_idle_zero("mid_reset");
        tick(); rst = 1'b0;
        tick(); tick();
        chk_idle_zero("post_reset");

        bb = 3'b000; start = 1'b1;
        tick();
        for (int c = 1; c <= DC0 + 2; c++) begin
            chk("h_load", load, (c == 1 || c == DC0 + 2));
            chk("h_done", done, (c == DC0));
            if (c == DC0 + 2) chk("h_iter_at_load", iter, 3'd4);
            if (c == DC0 + 2) start = 1'b0;
            tick();
        end
        repeat (DC0 + 1) tick();
        chk("h_end_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

- Sequencing FSM for the radix-4 Booth multiplier datapath.
- Accepts a start request and issues the load strobe to the operand/product shift registers.
- Recodes the multiplier triplet presented by the datapath into add/subtract commands, and issues the 2-bit right-shift strobes for N/2 iterations.
- Signals completion with a one-cycle done pulse.
- Sits between the multiplier's top-level handshake and the shift/adder datapath; the datapath and adder are external.

## Interface
- `N`, 8, operand width in bits; must be even and ≥ 4.
- `CNT_W`, `$clog2(N/2)+1`, iteration counter width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin a multiply; sampled only in IDLE.
- `booth_bits`  in  3  {Q[1], Q[0], q_-1} from datapath.
- `load`  out  1  drives datapath `set`; loads operands, clears accumulator.
- `shift`  out  1  drives datapath `shift` (2-bit arithmetic right shift).
- `add_en`  out  1  accumulator write enable for this cycle.
- `op_sel`  out  2  00 = zero, 01 = ±M, 10 = ±2M.
- `op_neg`  out  1  1 = subtract selected multiple.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `iter`  out  CNT_W  completed iterations.

## Operation
- States:
  - IDLE:
    - start=1 → LOAD; else stay.
  - LOAD:
    - Assert load; clear iter → EVAL.
  - EVAL:
    - Recode booth_bits and drive op_sel/op_neg.
    - add_en = (op_sel ≠ 00).
    - → SHIFT.
  - SHIFT:
    - Assert shift; iter += 1.
    - If iter was N/2−1 → DONE, else → EVAL.
  - DONE:
    - Assert done → IDLE.
- Recoding (booth_bits → op_sel, op_neg):
  - 000, 111 → 00, 0.
  - 001, 010 → 01, 0.
  - 011 → 10, 0.
  - 100 → 10, 1.
  - 101, 110 → 01, 1.
- Outside EVAL: op_sel = 00, op_neg = 0, add_en = 0.
- load, shift, add_en, done are decoded from state (Mealy only for the EVAL recode); they are never simultaneously high.
- start while busy (LOAD/EVAL/SHIFT/DONE): ignored, not queued.
- start held high continuously: new operation begins in the IDLE cycle after DONE.
- rst at any time: next state IDLE, iter = 0, all outputs 0 from the following cycle. A partially computed product in the datapath is don't-care.
- iter holds its final value (N/2) through DONE and IDLE until the next LOAD.

## Timing
- Reset values: busy = 0, done = 0, load = 0, shift = 0, add_en = 0, op_sel = 00, op_neg = 0, iter = 0.
- start sampled high at edge k:
  - LOAD occupies cycle k+1.
  - EVAL/SHIFT pairs occupy cycles k+2 … k+1+N.
  - DONE occupies cycle k+2+N.
  - IDLE from k+3+N.
- Example, N = 8: done high in cycle k+10. The product is valid in the datapath from the cycle done is high.
- booth_bits must be stable and reflect the post-shift register contents during every EVAL cycle. The datapath registers shift at the end of SHIFT, so this holds with no extra wait state.

## Configuration
- `BOOTH_SKIP_ZERO_EN` defined:
  - In EVAL, when recoded op_sel = 00, shift is asserted in the same cycle and iter increments.
  - The FSM goes directly to the next EVAL, or to DONE if that was the last iteration; SHIFT is skipped.
  - Latency becomes data-dependent: minimum N/2+2 cycles start-to-done, maximum N+2.
- Not defined: fixed two cycles per iteration; latency always N+2.

## Structure
- Package `booth_pkg`:
  - State enum (IDLE, LOAD, EVAL, SHIFT, DONE).
  - op_sel encoding constants (OP_ZERO, OP_M, OP_2M).
  - Reset-value constants.
- Sub-module `booth_recode`: purely combinational, 3-bit triplet → {op_sel, op_neg}. Instantiated once; reusable by the datapath's self-check.

## Test plan
- Reset:
  - Assert rst for 2 cycles mid-run → all outputs 0 and iter = 0 next cycle.
  - busy = 0 until start.
- N = 8, booth_bits held 000, start pulse at k:
  - load at k+1; 4 shift pulses at k+3, k+5, k+7, k+9.
  - done only at k+10; add_en never high; iter = 4 at done.
- booth_bits = 011 in EVAL → op_sel = 10, op_neg = 0, add_en = 1.
- booth_bits = 100 → op_sel = 10, op_neg = 1.
- booth_bits = 110 → op_sel = 01, op_neg = 1.
- start re-pulsed at k+4 during busy → ignored; done at k+10 only; no second LOAD.
- With `BOOTH_SKIP_ZERO_EN` and booth_bits 111 throughout → done at k+6. With alternating 011/000 triplets → done at k+8.
